wb_cmd_master: RTL and testbench
================================

# wb_cmd_master

Single-transaction Wishbone (pipelined, B4) bus master that converts a valid/ready command stream into one bus cycle at a time and returns each result on a valid/ready response stream. It lets control logic or a debug bridge drive simple register peripherals such as the GPIO controller, which acks in the same cycle as its strobe. A bounded timeout guarantees a response even if the addressed peripheral never answers.

## Interface
- AW, 30: word address width
- DW, 32: data width; must be a multiple of 8
- TIMEOUT, 255: cycles allowed from strobe issue to ack/err; legal range 1..65535
- i_clk  in  1  system clock
- i_reset_n  in  1  reset, asynchronous, active-low
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  command accepted when both high
- i_cmd_we  in  1  1 = write, 0 = read
- i_cmd_addr  in  AW  word address
- i_cmd_data  in  DW  write data
- i_cmd_sel  in  DW/8  byte enables
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  response consumed when both high
- o_rsp_data  out  DW  read data; 0 for writes and for errors
- o_rsp_err  out  1  bus error or timeout
- o_rsp_timeout  out  1  error was caused by timeout
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone controls
- o_wb_addr  out  AW  Wishbone address
- o_wb_data  out  DW  Wishbone write data
- o_wb_sel  out  DW/8  Wishbone byte select
- i_wb_stall, i_wb_ack, i_wb_err  in  1 each  Wishbone responses
- i_wb_data  in  DW  Wishbone read data

## Operation
- States:
  - IDLE: o_cmd_ready=1.
  - REQ: cyc=1, stb=1.
  - WAIT: cyc=1, stb=0.
  - RESP: o_rsp_valid=1.
- IDLE→REQ on i_cmd_valid. Latch we/addr/data/sel into the o_wb_* registers.
- REQ: strobe accepted when !i_wb_stall.
  - If i_wb_ack or i_wb_err is high in the same accepted cycle, go straight to RESP and drop cyc/stb.
  - Otherwise go to WAIT.
  - Ack/err seen while i_wb_stall=1 is ignored.
- WAIT: the first i_wb_ack or i_wb_err completes the cycle and moves to RESP with cyc=0.
  - If ack and err arrive together, err wins.
- Response capture:
  - Ack on a read: o_rsp_data=i_wb_data.
  - Ack on a write: o_rsp_data=0.
  - Err: err=1, data=0.
- Timeout:
  - The counter clears on REQ entry and increments every cycle in REQ/WAIT.
  - When it reaches TIMEOUT with no ack/err, drop cyc/stb and go to RESP with err=1, timeout=1.
  - Ack on the timeout cycle itself wins over the timeout.
- RESP→IDLE on i_rsp_ready. Response fields hold stable while o_rsp_valid && !i_rsp_ready.
- Acks/errs arriving outside REQ/WAIT are ignored.
- o_wb_addr/data/sel/we hold their values after a cycle ends; only cyc/stb are meaningful.

## Timing
- Reset values:
  - All outputs 0 except o_cmd_ready=1.
  - State IDLE, counter 0.
- Asserting reset mid-cycle drops o_wb_cyc/o_wb_stb asynchronously, and the in-flight command is lost without a response.
- All outputs are registered, or decoded directly from the state register.
- Command accepted at edge N:
  - cyc/stb high in cycle N+1.
  - With a zero-wait responder (stall=0, ack in the same cycle), o_rsp_valid is high in cycle N+2.
- Stall of S cycles plus ack delay of D cycles after acceptance gives o_rsp_valid at N+2+S+D.
- Peak throughput: one command per 3 cycles (IDLE, REQ, RESP).
- Timeout response appears at N+2+TIMEOUT. The counter is at least 16 bits wide.

## Structure
- Package wb_cmd_pkg holds:
  - State enum: IDLE=2'd0, REQ=2'd1, WAIT=2'd2, RESP=2'd3.
  - Default TIMEOUT constant.
- Sub-module wb_cmd_timer: clear/enable/expired counter, parameterized by TIMEOUT. This is the only natural split; everything else lives in the top module.

## Test plan
- Write 0x0001_0001 to addr 0x10, sel 4'hF, zero-wait acking responder:
  - cyc/stb high exactly one cycle.
  - o_rsp_valid two cycles after acceptance, err=0, data=0.
- Read addr 0x10, responder returns 0xA5A5_0003 with ack 3 cycles after strobe:
  - o_rsp_data=0xA5A5_0003, err=0.
  - cyc low the cycle after ack.
- Stall held 4 cycles, then ack two cycles later:
  - stb high 5 cycles.
  - Ack during stall ignored.
  - Response at N+2+4+2.
- i_wb_err with ack in the same cycle → err=1, timeout=0, data=0.
- TIMEOUT=16, no response → cyc drops, err=1, timeout=1 at N+18. A late ack at N+20 is ignored.
- Response backpressure: i_rsp_ready low 5 cycles.
  - Fields stable, o_cmd_ready=0 throughout.
  - Reset asserted mid-WAIT drops cyc immediately and comes back IDLE with o_cmd_ready=1.

Source files
------------

// File: rtl/wb_cmd_pkg.sv
// Shared types and constants for the single-transaction Wishbone command master.
package wb_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // Default bus-cycle timeout, in clocks from strobe issue to ack/err.
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    // Timer width; covers the full legal timeout range up to 65535.
    localparam int unsigned TMR_W = 16;

endpackage

// File: rtl/wb_cmd_master_timer.sv
// Bus-cycle watchdog: clears on cycle start, counts while a cycle is open,
// flags expiry once the count reaches TIMEOUT.
import wb_cmd_pkg::*;

module wb_cmd_timer #(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [TMR_W-1:0] TERM = TMR_W'(TIMEOUT);

    logic [TMR_W-1:0] count;

    // Up-counter that parks at the terminal value so it can never wrap.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_enable && (count != TERM)) begin
            count <= count + 1'b1;
        end
    end

    assign o_expired = (count == TERM);

endmodule

// File: rtl/wb_cmd_master.sv
// Converts a valid/ready command stream into one pipelined Wishbone cycle at
// a time and returns the outcome on a valid/ready response stream.
//
// state | meaning
// IDLE  | ready for a command (o_cmd_ready=1)
// REQ   | strobe on the bus, waiting for !stall
// WAIT  | strobe accepted, waiting for ack/err
// RESP  | response held until consumed
import wb_cmd_pkg::*;

module wb_cmd_master #(
    parameter int unsigned AW      = 30,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic          i_cmd_we,
    input  logic [AW-1:0] i_cmd_addr,
    input  logic [DW-1:0] i_cmd_data,
    input  logic [DW/8-1:0] i_cmd_sel,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [DW-1:0] o_rsp_data,
    output logic          o_rsp_err,
    output logic          o_rsp_timeout,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [DW-1:0] o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic          i_wb_stall,
    input  logic          i_wb_ack,
    input  logic          i_wb_err,
    input  logic [DW-1:0] i_wb_data
);

    state_t state;
    logic   tmr_clear;
    logic   tmr_enable;
    logic   tmr_expired;
    logic   bus_done;

    assign tmr_clear  = (state == IDLE) && i_cmd_valid;
    assign tmr_enable = (state == REQ) || (state == WAIT);

    wb_cmd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (tmr_clear),
        .i_enable  (tmr_enable),
        .o_expired (tmr_expired)
    );

    // A completing ack/err only counts once the strobe is (or was) accepted.
    assign bus_done = (i_wb_ack || i_wb_err) &&
                      ((state == WAIT) || ((state == REQ) && !i_wb_stall));

    // Control strobes decode straight from state so reset drops them at once.
    assign o_cmd_ready = (state == IDLE);
    assign o_wb_cyc    = (state == REQ) || (state == WAIT);
    assign o_wb_stb    = (state == REQ);
    assign o_rsp_valid = (state == RESP);

    // Sequencer: latches the command, tracks the bus cycle, captures the result.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            o_wb_we       <= 1'b0;
            o_wb_addr     <= '0;
            o_wb_data     <= '0;
            o_wb_sel      <= '0;
            o_rsp_data    <= '0;
            o_rsp_err     <= 1'b0;
            o_rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        o_wb_we   <= i_cmd_we;
                        o_wb_addr <= i_cmd_addr;
                        o_wb_data <= i_cmd_data;
                        o_wb_sel  <= i_cmd_sel;
                        state     <= REQ;
                    end
                end
                REQ, WAIT: begin
                    // A real answer on the expiry cycle beats the timeout.
                    if (bus_done) begin
                        o_rsp_err     <= i_wb_err;
                        o_rsp_timeout <= 1'b0;
                        o_rsp_data    <= (!i_wb_err && !o_wb_we) ? i_wb_data : '0;
                        state         <= RESP;
                    end else if (tmr_expired) begin
                        o_rsp_err     <= 1'b1;
                        o_rsp_timeout <= 1'b1;
                        o_rsp_data    <= '0;
                        state         <= RESP;
                    end else if ((state == REQ) && !i_wb_stall) begin
                        state <= WAIT;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master, built with a 16-cycle timeout.
`timescale 1ns/1ps
module tb_wb_cmd_master;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic          i_cmd_we;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_data;
    logic [3:0]    i_cmd_sel;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [DW-1:0] o_rsp_data;
    logic          o_rsp_err;
    logic          o_rsp_timeout;
    logic          o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [DW-1:0] o_wb_data;
    logic [3:0]    o_wb_sel;
    logic          i_wb_stall, i_wb_ack, i_wb_err;
    logic [DW-1:0] i_wb_data;

    int checks = 0;
    int errors = 0;

    wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_we      (i_cmd_we),
        .i_cmd_addr    (i_cmd_addr),
        .i_cmd_data    (i_cmd_data),
        .i_cmd_sel     (i_cmd_sel),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_data    (o_rsp_data),
        .o_rsp_err     (o_rsp_err),
        .o_rsp_timeout (o_rsp_timeout),
        .o_wb_cyc      (o_wb_cyc),
        .o_wb_stb      (o_wb_stb),
        .o_wb_we       (o_wb_we),
        .o_wb_addr     (o_wb_addr),
        .o_wb_data     (o_wb_data),
        .o_wb_sel      (o_wb_sel),
        .i_wb_stall    (i_wb_stall),
        .i_wb_ack      (i_wb_ack),
        .i_wb_err      (i_wb_err),
        .i_wb_data     (i_wb_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Present one command for a single accepted edge; returns in cycle N+1.
    task automatic issue(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [3:0] sel);
        i_cmd_valid = 1'b1;
        i_cmd_we    = we;
        i_cmd_addr  = addr;
        i_cmd_data  = data;
        i_cmd_sel   = sel;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    initial begin
        i_reset_n   = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_we    = 1'b0;
        i_cmd_addr  = '0;
        i_cmd_data  = '0;
        i_cmd_sel   = '0;
        i_rsp_ready = 1'b1;
        i_wb_stall  = 1'b0;
        i_wb_ack    = 1'b0;
        i_wb_err    = 1'b0;
        i_wb_data   = '0;
        #22;
        chk("rst_cmd_ready", 64'(o_cmd_ready), 64'd1);
        chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("rst_cyc_stb",   64'({o_wb_cyc, o_wb_stb, o_wb_we}), 64'd0);
        chk("rst_rsp_flds",  64'({o_rsp_err, o_rsp_timeout, o_rsp_data}), 64'd0);
        chk("rst_wb_flds",   64'({o_wb_addr, o_wb_sel}), 64'd0);
        i_reset_n = 1'b1;
        tick();

        // Write with a zero-wait acking responder.
        issue(1'b1, 30'h10, 32'h0001_0001, 4'hF);
        chk("wr_n1_cyc_stb", 64'({o_wb_cyc, o_wb_stb, o_wb_we}), 64'b111);
        chk("wr_n1_addr",    64'(o_wb_addr), 64'h10);
        chk("wr_n1_data",    64'({o_wb_data, o_wb_sel}), {28'd0, 32'h0001_0001, 4'hF});
        chk("wr_n1_ready",   64'({o_cmd_ready, o_rsp_valid}), 64'b00);
        i_wb_ack = 1'b1;
        tick();
        i_wb_ack = 1'b0;
        chk("wr_n2_cyc",     64'({o_wb_cyc, o_wb_stb}), 64'b00);
        chk("wr_n2_rsp",     64'({o_rsp_valid, o_rsp_err, o_rsp_timeout}), 64'b100);
        chk("wr_n2_data",    64'(o_rsp_data), 64'd0);
        tick();
        chk("wr_idle",       64'({o_cmd_ready, o_rsp_valid}), 64'b10);

        // Read acked three cycles after the strobe.
        issue(1'b0, 30'h10, 32'h0, 4'hF);
        chk("rd_n1_stb",     64'({o_wb_cyc, o_wb_stb, o_wb_we}), 64'b110);
        tick();
        chk("rd_n2_wait",    64'({o_wb_cyc, o_wb_stb}), 64'b10);
        tick();
        tick();
        i_wb_ack  = 1'b1;
        i_wb_data = 32'hA5A5_0003;
        chk("rd_n4_norsp",   64'({o_wb_cyc, o_rsp_valid}), 64'b10);
        tick();
        i_wb_ack  = 1'b0;
        i_wb_data = 32'h0;
        chk("rd_n5_cyc",     64'(o_wb_cyc), 64'd0);
        chk("rd_n5_rsp",     64'({o_rsp_valid, o_rsp_err}), 64'b10);
        chk("rd_n5_data",    64'(o_rsp_data), 64'hA5A5_0003);
        tick();

        // Stall for four cycles with a bogus ack in the first, then ack two later.
        issue(1'b0, 30'h24, 32'h0, 4'h3);
        i_wb_stall = 1'b1;
        i_wb_ack   = 1'b1;
        i_wb_data  = 32'hBAD0_BAD0;
        for (int k = 0; k < 5; k++) begin
            chk("st_stb_high", 64'({o_wb_stb, o_rsp_valid}), 64'b10);
            tick();
            i_wb_ack = 1'b0;
            if (k == 3) i_wb_stall = 1'b0;
        end
        chk("st_n6_wait",    64'({o_wb_cyc, o_wb_stb}), 64'b10);
        tick();
        i_wb_ack  = 1'b1;
        i_wb_data = 32'h1234_5678;
        chk("st_n7_norsp",   64'(o_rsp_valid), 64'd0);
        tick();
        i_wb_ack  = 1'b0;
        i_wb_data = 32'h0;
        chk("st_n8_rsp",     64'({o_rsp_valid, o_rsp_err, o_wb_cyc}), 64'b100);
        chk("st_n8_data",    64'(o_rsp_data), 64'h1234_5678);
        tick();

        // Err and ack together: err wins, data forced to zero.
        issue(1'b0, 30'h30, 32'h0, 4'hF);
        i_wb_ack  = 1'b1;
        i_wb_err  = 1'b1;
        i_wb_data = 32'hFFFF_FFFF;
        tick();
        i_wb_ack  = 1'b0;
        i_wb_err  = 1'b0;
        i_wb_data = 32'h0;
        chk("err_rsp",       64'({o_rsp_valid, o_rsp_err, o_rsp_timeout}), 64'b110);
        chk("err_data",      64'(o_rsp_data), 64'd0);
        tick();

        // Silent peripheral: timeout response at N+18, late ack at N+20 ignored.
        issue(1'b0, 30'h40, 32'h0, 4'hF);
        for (int k = 0; k < 16; k++) tick();
        chk("to_n17_open",   64'({o_wb_cyc, o_rsp_valid}), 64'b10);
        tick();
        chk("to_n18_rsp",    64'({o_rsp_valid, o_rsp_err, o_rsp_timeout, o_wb_cyc}), 64'b1110);
        chk("to_n18_data",   64'(o_rsp_data), 64'd0);
        tick();
        tick();
        i_wb_ack  = 1'b1;
        i_wb_data = 32'h5555_AAAA;
        tick();
        i_wb_ack  = 1'b0;
        chk("to_late_ack",   64'({o_cmd_ready, o_rsp_valid, o_wb_cyc}), 64'b100);

        // Backpressure: response fields must hold while the consumer stalls.
        issue(1'b0, 30'h50, 32'h0, 4'hF);
        i_wb_ack  = 1'b1;
        i_wb_data = 32'hDEAD_BEEF;
        i_rsp_ready = 1'b0;
        tick();
        i_wb_ack    = 1'b0;
        i_cmd_valid = 1'b1;
        i_cmd_addr  = 30'h3FF;
        for (int k = 0; k < 5; k++) begin
            i_wb_data = 32'(k) * 32'h0101_0101;
            i_wb_err  = k[0];
            chk("bp_hold",   64'({o_rsp_valid, o_cmd_ready, o_rsp_err, o_rsp_timeout}), 64'b1000);
            chk("bp_data",   64'(o_rsp_data), 64'hDEAD_BEEF);
            tick();
        end
        i_wb_err    = 1'b0;
        i_cmd_valid = 1'b0;
        chk("bp_addr_kept",  64'(o_wb_addr), 64'h50);
        i_rsp_ready = 1'b1;
        tick();
        chk("bp_release",    64'({o_cmd_ready, o_rsp_valid}), 64'b10);

        // Reset during WAIT drops cyc without waiting for a clock edge.
        issue(1'b0, 30'h60, 32'h0, 4'hF);
        tick();
        chk("rw_wait",       64'({o_wb_cyc, o_wb_stb}), 64'b10);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("rw_async_cyc",  64'({o_wb_cyc, o_wb_stb}), 64'b00);
        chk("rw_ready",      64'({o_cmd_ready, o_rsp_valid}), 64'b10);
        #3;
        i_reset_n = 1'b1;
        i_wb_ack  = 1'b1;
        tick();
        i_wb_ack  = 1'b0;
        tick();
        chk("rw_idle",       64'({o_cmd_ready, o_rsp_valid, o_wb_cyc}), 64'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
